alu_2bits_issue: RTL and testbench
==================================

ALU_2BITS_ISSUE -- requirements
Module: alu_2bits_issue

Interface
REQ-001 The block SHALL have parameter REG_INIT, default 2'b00, the reset value of every register-file entry.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port instr_valid, input, 1, the instruction-offered strobe.
REQ-005 The block SHALL have port instr, input, 9, the instruction: [8:6] opcode, [5:4] rd, [3:2] rs1 address, [1:0] rs2 address.
REQ-006 The block SHALL have port instr_ready, output, 1, the block-can-accept indicator.
REQ-007 The block SHALL have ports alu_rs1, alu_rs2, alu_opcode, outputs, 2/2/3, the operands and opcode driven to the 2-bit ALU.
REQ-008 The block SHALL have port alu_result, input, 2, the combinational ALU result (0 add, 1 sub, 2 shl, 3 shr, 4 and, 5 or, 6 xor, 7 not rs1).
REQ-009 The block SHALL have ports wb_valid, wb_rd, wb_data, outputs, 1/2/2, the one-cycle writeback pulse, destination and value.
REQ-010 The block SHALL have ports dbg_addr (input, 2) and dbg_data (output, 2), a combinational register-file read port.

Function
REQ-011 The block SHALL contain a 4-entry x 2-bit register file and a 4-state FSM: IDLE, DECODE, EXEC, WB.
REQ-012 The instr_ready output SHALL be 1 only in IDLE; an instruction is accepted when instr_valid and instr_ready are both 1 at a clock edge.
REQ-013 On acceptance, the instr word SHALL be latched and the state SHALL go IDLE->DECODE; instr changes after acceptance SHALL have no effect.
REQ-014 In DECODE, the block SHALL read regfile[rs1] and regfile[rs2] into operand registers and go to EXEC.
REQ-015 In EXEC, alu_rs1, alu_rs2 and alu_opcode SHALL be stable from the operand registers; the block SHALL capture alu_result at the closing edge and go to WB.
REQ-016 In WB, the block SHALL write the captured result to regfile[rd], assert wb_valid for exactly one cycle with wb_rd/wb_data, and return to IDLE.
REQ-017 Latency SHALL be fixed: wb_valid asserts 3 cycles after the acceptance edge; the issue rate SHALL be one instruction per 4 cycles.
REQ-018 When rd equals rs1 or rs2, the block SHALL use the old register values as operands; the write SHALL take effect after WB.
REQ-019 For opcode 7, rs2 SHALL still be read and driven but SHALL NOT affect the result.
REQ-020 Arithmetic SHALL be modulo 4 and carries/borrows SHALL be discarded; the block SHALL NOT alter alu_result.
REQ-021 Outside EXEC, alu_rs1/alu_rs2/alu_opcode SHALL hold their last values, and wb_valid SHALL be 0 outside WB.
REQ-022 Writes through dbg_data SHALL become visible on the cycle after the WB edge.

Reset
REQ-023 Asserting rst_n low SHALL immediately force the following: state IDLE, all regfile entries REG_INIT, operand/instr registers 0, alu_* 0, wb_valid 0, wb_rd 0, wb_data 0, instr_ready 0 while rst_n is low.
REQ-024 A reset during DECODE/EXEC/WB SHALL abort the instruction with no writeback; instr_ready SHALL be 1 on the first clock after rst_n deasserts.

Configuration
REQ-025 With macro ALU_ISSUE_ZFLAG_EN defined, the block SHALL add output zflag (1 bit, reset 0), set in WB to (result==0) and held otherwise.
REQ-026 Without ALU_ISSUE_ZFLAG_EN, the zflag port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-027 Reset, REG_INIT=0: instr {0,r1,r0,r0} -> wb_valid 3 cycles after acceptance, wb_rd=1, wb_data=0; dbg_addr=1 reads 0.
REQ-028 Preload r1=3 via opcode 7 on r0 (~0=3 into r1), then {0,r2,r1,r1} -> wb_data=2 (3+3 mod 4).
REQ-029 r1=3: {1,r1,r0,r1} -> wb_data=1 (0-3 mod 4), rd==rs2 uses old r1=3; zflag=0 when the macro is enabled.
REQ-030 Hold instr_valid high continuously -> instr_ready pulses once per 4 cycles; exactly one wb_valid per acceptance; instr changed mid-op is ignored.
REQ-031 Drop rst_n in EXEC -> no wb_valid, regfile back to REG_INIT, instr_ready=1 on the first edge after release.
REQ-032 With the macro enabled: {6,r3,r1,r1} -> wb_data=0 and zflag=1; a following op producing a nonzero result -> zflag=0.

Source files
------------

// File: rtl/alu_2bits_issue.sv
// Issue/writeback sequencer for an external 2-bit ALU: 4x2-bit register file, IDLE/DECODE/EXEC/WB FSM.
// Optional macro ALU_ISSUE_ZFLAG_EN adds a registered zero flag output (zflag).
module alu_2bits_issue #(
  parameter logic [1:0] REG_INIT = 2'b00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [8:0] instr,
  output logic       instr_ready,
  output logic [1:0] alu_rs1,
  output logic [1:0] alu_rs2,
  output logic [2:0] alu_opcode,
  input  logic [1:0] alu_result,
  output logic       wb_valid,
  output logic [1:0] wb_rd,
  output logic [1:0] wb_data,
  input  logic [1:0] dbg_addr,
  output logic [1:0] dbg_data
`ifdef ALU_ISSUE_ZFLAG_EN
  ,
  output logic       zflag
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  instr_q, instr_d;
  logic [1:0]  op1_q, op1_d;
  logic [1:0]  op2_q, op2_d;
  logic [2:0]  opc_q, opc_d;
  logic        ready_q, ready_d;
  logic        wbv_q, wbv_d;
  logic [1:0]  wbrd_q, wbrd_d;
  logic [1:0]  wbdata_q, wbdata_d;
  logic [1:0]  rf_q [4];
  logic [1:0]  rf_d [4];

  // Operand registers double as the ALU drive, so they hold outside EXEC for free.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    opc_d    = opc_q;
    ready_d  = ready_q;
    wbv_d    = 1'b0;
    wbrd_d   = wbrd_q;
    wbdata_d = wbdata_q;
    rf_d     = rf_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (instr_valid && ready_q) begin
          instr_d = instr;
          ready_d = 1'b0;
          state_d = DECODE;
        end
      end
      DECODE: begin
        op1_d   = rf_q[instr_q[3:2]];
        op2_d   = rf_q[instr_q[1:0]];
        opc_d   = instr_q[8:6];
        state_d = EXEC;
      end
      EXEC: begin
        wbv_d    = 1'b1;
        wbrd_d   = instr_q[5:4];
        wbdata_d = alu_result;
        state_d  = WB;
      end
      WB: begin
        // Register write lands on the edge that leaves WB, so operands read earlier saw old values.
        rf_d[wbrd_q] = wbdata_q;
        ready_d      = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      opc_q    <= '0;
      ready_q  <= 1'b0;
      wbv_q    <= 1'b0;
      wbrd_q   <= '0;
      wbdata_q <= '0;
      for (int i = 0; i < 4; i++) rf_q[i] <= REG_INIT;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      opc_q    <= opc_d;
      ready_q  <= ready_d;
      wbv_q    <= wbv_d;
      wbrd_q   <= wbrd_d;
      wbdata_q <= wbdata_d;
      for (int i = 0; i < 4; i++) rf_q[i] <= rf_d[i];
    end
  end

`ifdef ALU_ISSUE_ZFLAG_EN
  logic zflag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zflag_q <= 1'b0;
    end else if (state_q == EXEC) begin
      zflag_q <= (alu_result == 2'b00);
    end
  end

  assign zflag = zflag_q;
`endif

  assign instr_ready = ready_q;
  assign alu_rs1     = op1_q;
  assign alu_rs2     = op2_q;
  assign alu_opcode  = opc_q;
  assign wb_valid    = wbv_q;
  assign wb_rd       = wbrd_q;
  assign wb_data     = wbdata_q;
  assign dbg_data    = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_2bits_issue.sv
// Directed bench for alu_2bits_issue; a behavioural 2-bit ALU closes the loop on alu_result.
module tb_alu_2bits_issue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       instr_valid = 1'b0;
  logic [8:0] instr = '0;
  logic       instr_ready;
  logic [1:0] alu_rs1, alu_rs2;
  logic [2:0] alu_opcode;
  logic [1:0] alu_result;
  logic       wb_valid;
  logic [1:0] wb_rd, wb_data;
  logic [1:0] dbg_addr = '0;
  logic [1:0] dbg_data;
`ifdef ALU_ISSUE_ZFLAG_EN
  logic       zflag;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  alu_2bits_issue #(.REG_INIT(2'b00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_ready(instr_ready),
    .alu_rs1    (alu_rs1),
    .alu_rs2    (alu_rs2),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
`ifdef ALU_ISSUE_ZFLAG_EN
    ,
    .zflag      (zflag)
`endif
  );

  // Reference ALU: 0 add, 1 sub, 2 shl, 3 shr, 4 and, 5 or, 6 xor, 7 not rs1.
  always_comb begin
    alu_result = 2'b00;
    case (alu_opcode)
      3'd0: alu_result = 2'(alu_rs1 + alu_rs2);
      3'd1: alu_result = 2'(alu_rs1 - alu_rs2);
      3'd2: alu_result = 2'(alu_rs1 << alu_rs2);
      3'd3: alu_result = 2'(alu_rs1 >> alu_rs2);
      3'd4: alu_result = alu_rs1 & alu_rs2;
      3'd5: alu_result = alu_rs1 | alu_rs2;
      3'd6: alu_result = alu_rs1 ^ alu_rs2;
      default: alu_result = ~alu_rs1;
    endcase
  end

  // Offers one instruction, scrambles instr after acceptance, and records what the DUT does
  // over the following six negedges (k = 1 is the negedge just after the acceptance edge).
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, output int cnt, output int kfirst,
                       output logic [1:0] rdo, output logic [1:0] datao,
                       output logic [1:0] a1, output logic [1:0] a2,
                       output logic [2:0] aop, output logic zo);
    logic ok;
    cnt = 0; kfirst = 0; rdo = '0; datao = '0; a1 = '0; a2 = '0; aop = '0; zo = 1'b0; ok = 1'b0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr = {op, rd, rs1, rs2};
    for (int i = 0; i < 10 && !ok; i++) begin
      if (instr_ready) ok = 1'b1;
      else @(negedge clk);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        instr_valid = 1'b0;
        instr = 9'h1FF;
      end
      if (k == 2) begin
        a1 = alu_rs1; a2 = alu_rs2; aop = alu_opcode;
      end
      if (wb_valid) begin
        cnt++;
        if (kfirst == 0) begin
          kfirst = k; rdo = wb_rd; datao = wb_data;
`ifdef ALU_ISSUE_ZFLAG_EN
          zo = zflag;
`endif
        end
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (instr_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", instr_ready); else passed++;
    checks++; if (wb_valid !== 1'b0) $display("FAIL rst_wb_valid got %b want 0", wb_valid); else passed++;
    checks++; if (alu_opcode !== 3'd0) $display("FAIL rst_alu_opcode got %0d want 0", alu_opcode); else passed++;
    checks++; if (alu_rs1 !== 2'd0) $display("FAIL rst_alu_rs1 got %0d want 0", alu_rs1); else passed++;
    checks++; if (wb_data !== 2'd0) $display("FAIL rst_wb_data got %0d want 0", wb_data); else passed++;
`ifdef ALU_ISSUE_ZFLAG_EN
    checks++; if (zflag !== 1'b0) $display("FAIL rst_zflag got %b want 0", zflag); else passed++;
`endif
    for (int a = 0; a < 4; a++) begin
      dbg_addr = 2'(a);
      #1;
      checks++; if (dbg_data !== 2'b00) $display("FAIL rst_rf%0d got %0d want 0", a, dbg_data); else passed++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (instr_ready !== 1'b0) $display("FAIL ready_at_release got %b want 0", instr_ready); else passed++;
    @(negedge clk);
    checks++; if (instr_ready !== 1'b1) $display("FAIL ready_after_release got %b want 1", instr_ready); else passed++;
  endtask

  task automatic test_add_zero();
    int cnt, kf; logic [1:0] r, d, a1, a2; logic [2:0] aop; logic z;
    issue(3'd0, 2'd1, 2'd0, 2'd0, cnt, kf, r, d, a1, a2, aop, z);
    checks++; if (cnt !== 1) $display("FAIL add0_wb_count got %0d want 1", cnt); else passed++;
    checks++; if (kf !== 3) $display("FAIL add0_latency got %0d want 3", kf); else passed++;
    checks++; if (r !== 2'd1) $display("FAIL add0_wb_rd got %0d want 1", r); else passed++;
    checks++; if (d !== 2'd0) $display("FAIL add0_wb_data got %0d want 0", d); else passed++;
    dbg_addr = 2'd1; #1;
    checks++; if (dbg_data !== 2'd0) $display("FAIL add0_dbg_r1 got %0d want 0", dbg_data); else passed++;
  endtask

  task automatic test_preload_add();
    int cnt, kf; logic [1:0] r, d, a1, a2; logic [2:0] aop; logic z;
    issue(3'd7, 2'd1, 2'd0, 2'd0, cnt, kf, r, d, a1, a2, aop, z);
    checks++; if (aop !== 3'd7) $display("FAIL not_alu_opcode got %0d want 7", aop); else passed++;
    checks++; if (d !== 2'd3) $display("FAIL not_wb_data got %0d want 3", d); else passed++;
    dbg_addr = 2'd1; #1;
    checks++; if (dbg_data !== 2'd3) $display("FAIL not_dbg_r1 got %0d want 3", dbg_data); else passed++;
    issue(3'd0, 2'd2, 2'd1, 2'd1, cnt, kf, r, d, a1, a2, aop, z);
    checks++; if (a1 !== 2'd3) $display("FAIL add33_alu_rs1 got %0d want 3", a1); else passed++;
    checks++; if (d !== 2'd2) $display("FAIL add33_wb_data got %0d want 2", d); else passed++;
    checks++; if (r !== 2'd2) $display("FAIL add33_wb_rd got %0d want 2", r); else passed++;
    dbg_addr = 2'd2; #1;
    checks++; if (dbg_data !== 2'd2) $display("FAIL add33_dbg_r2 got %0d want 2", dbg_data); else passed++;
  endtask

  task automatic test_sub_rd_eq_rs2();
    int cnt, kf; logic [1:0] r, d, a1, a2; logic [2:0] aop; logic z;
    issue(3'd1, 2'd1, 2'd0, 2'd1, cnt, kf, r, d, a1, a2, aop, z);
    checks++; if (a2 !== 2'd3) $display("FAIL sub_old_rs2 got %0d want 3", a2); else passed++;
    checks++; if (d !== 2'd1) $display("FAIL sub_wb_data got %0d want 1", d); else passed++;
`ifdef ALU_ISSUE_ZFLAG_EN
    checks++; if (z !== 1'b0) $display("FAIL sub_zflag got %b want 0", z); else passed++;
`endif
    dbg_addr = 2'd1; #1;
    checks++; if (dbg_data !== 2'd1) $display("FAIL sub_dbg_r1 got %0d want 1", dbg_data); else passed++;
  endtask

  task automatic test_not_ignores_rs2();
    int cnt, kf; logic [1:0] r, d, a1, a2; logic [2:0] aop; logic z;
    issue(3'd7, 2'd3, 2'd2, 2'd1, cnt, kf, r, d, a1, a2, aop, z);
    checks++; if (a2 !== 2'd1) $display("FAIL not_rs2_driven got %0d want 1", a2); else passed++;
    checks++; if (d !== 2'd1) $display("FAIL not2_wb_data got %0d want 1", d); else passed++;
    dbg_addr = 2'd3; #1;
    checks++; if (dbg_data !== 2'd1) $display("FAIL not2_dbg_r3 got %0d want 1", dbg_data); else passed++;
  endtask

  task automatic test_zflag();
    int cnt, kf; logic [1:0] r, d, a1, a2; logic [2:0] aop; logic z;
    issue(3'd6, 2'd3, 2'd1, 2'd1, cnt, kf, r, d, a1, a2, aop, z);
    checks++; if (d !== 2'd0) $display("FAIL xor_wb_data got %0d want 0", d); else passed++;
`ifdef ALU_ISSUE_ZFLAG_EN
    checks++; if (z !== 1'b1) $display("FAIL xor_zflag got %b want 1", z); else passed++;
`endif
    issue(3'd5, 2'd0, 2'd1, 2'd2, cnt, kf, r, d, a1, a2, aop, z);
    checks++; if (d !== 2'd3) $display("FAIL or_wb_data got %0d want 3", d); else passed++;
    checks++; if (r !== 2'd0) $display("FAIL or_wb_rd got %0d want 0", r); else passed++;
`ifdef ALU_ISSUE_ZFLAG_EN
    checks++; if (z !== 1'b0) $display("FAIL or_zflag got %b want 0", z); else passed++;
`endif
  endtask

  // r0=3, r1=1 here. A = r2 <- r0|r1 = 3; B (offered only while busy) would give r2 <- r0+r0 = 2.
  task automatic test_back_to_back();
    logic [8:0] ia, ib;
    int acc, wbn, last, gap_bad, bad;
    ia = {3'd5, 2'd2, 2'd0, 2'd1};
    ib = {3'd0, 2'd2, 2'd0, 2'd0};
    acc = 0; wbn = 0; last = -1; gap_bad = 0; bad = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      instr_valid = (i < 16);
      instr = instr_ready ? ia : ib;
      if (instr_valid && instr_ready) begin
        acc++;
        if (last >= 0 && (i - last) != 4) gap_bad++;
        last = i;
      end
      if (wb_valid) begin
        wbn++;
        if (wb_data !== 2'd3 || wb_rd !== 2'd2) bad++;
      end
    end
    instr_valid = 1'b0;
    checks++; if (acc !== 4) $display("FAIL b2b_accepts got %0d want 4", acc); else passed++;
    checks++; if (wbn !== 4) $display("FAIL b2b_wb_pulses got %0d want 4", wbn); else passed++;
    checks++; if (gap_bad !== 0) $display("FAIL b2b_issue_gap got %0d bad gaps want 0", gap_bad); else passed++;
    checks++; if (bad !== 0) $display("FAIL b2b_wb_payload got %0d bad pulses want 0", bad); else passed++;
    dbg_addr = 2'd2; #1;
    checks++; if (dbg_data !== 2'd3) $display("FAIL b2b_dbg_r2 got %0d want 3", dbg_data); else passed++;
  endtask

  // Instruction r3 <- r0+r0 (3+3=2) is aborted by reset while in EXEC.
  task automatic test_reset_exec();
    int wbn;
    @(negedge clk);
    instr_valid = 1'b1;
    instr = {3'd0, 2'd3, 2'd0, 2'd0};
    checks++; if (instr_ready !== 1'b1) $display("FAIL abort_ready_before got %b want 1", instr_ready); else passed++;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    checks++; if (alu_rs1 !== 2'd3) $display("FAIL abort_exec_rs1 got %0d want 3", alu_rs1); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b0) $display("FAIL abort_wb_valid got %b want 0", wb_valid); else passed++;
    checks++; if (instr_ready !== 1'b0) $display("FAIL abort_ready_in_rst got %b want 0", instr_ready); else passed++;
    checks++; if (alu_rs1 !== 2'd0) $display("FAIL abort_alu_rs1 got %0d want 0", alu_rs1); else passed++;
    dbg_addr = 2'd0; #1;
    checks++; if (dbg_data !== 2'd0) $display("FAIL abort_dbg_r0 got %0d want 0", dbg_data); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    wbn = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++; if (instr_ready !== 1'b1) $display("FAIL abort_ready_after got %b want 1", instr_ready); else passed++;
      end
      if (wb_valid) wbn++;
    end
    checks++; if (wbn !== 0) $display("FAIL abort_no_wb got %0d want 0", wbn); else passed++;
    dbg_addr = 2'd3; #1;
    checks++; if (dbg_data !== 2'd0) $display("FAIL abort_dbg_r3 got %0d want 0", dbg_data); else passed++;
  endtask

  initial begin
    test_reset();
    test_add_zero();
    test_preload_add();
    test_sub_rd_eq_rs2();
    test_not_ignores_rs2();
    test_zflag();
    test_back_to_back();
    test_reset_exec();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule
